// File: rtl/rr_arb4_ctrl_if.sv
// Client-side bundle for the four-way arbiter: request vector, mode select and registered grant outputs.
interface rr_arb4_ctrl_if;
    logic [3:0] req;
    logic       fixed_pri;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    modport master (output req, fixed_pri, input grant, grant_idx, grant_valid);
    modport slave  (input req, fixed_pri, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/rr_arb4_ctrl.sv
// Four-requester arbiter with registered one-hot grant, fixed or round-robin priority,
// grant held until release, and an optional hold-time limit that forces a handoff.
module rr_arb4_ctrl #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb4_ctrl_if.slave bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       win_all, win_msk;
    logic             timeout;

    // Returns {found, index}; later loop iterations override earlier ones, so loop order sets priority.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic fp, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        if (fp) begin
            for (int i = 0; i < 4; i++)
                if (r[i]) res = {1'b1, 2'(i)};
        end else begin
            for (int k = 4; k >= 1; k--) begin
                c = last + 2'(k);
                if (r[c]) res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign win_all = arbitrate(bus.req, bus.fixed_pri, last_q);
    assign win_msk = arbitrate(bus.req & ~grant_q, bus.fixed_pri, last_q);
    assign timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_SAT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (win_all[2]) begin
                    state_d = S_GRANT;
                    grant_d = 4'b0001 << win_all[1:0];
                    idx_d   = win_all[1:0];
                    valid_d = 1'b1;
                    cnt_d   = CNT_ONE;
                    last_d  = win_all[1:0];
                end
            end
            S_GRANT: begin
                if (!bus.req[idx_q] || timeout) begin
                    if (win_msk[2]) begin
                        grant_d = 4'b0001 << win_msk[1:0];
                        idx_d   = win_msk[1:0];
                        cnt_d   = CNT_ONE;
                        last_d  = win_msk[1:0];
                    end else if (timeout && bus.req[idx_q]) begin
                        // Sole requester at the limit: re-grant in place, grant never drops.
                        cnt_d = CNT_ONE;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 4'b0000;
                        idx_d   = 2'b00;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 4'b0000;
            idx_q   <= 2'b00;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Bench for rr_arb4_ctrl: one instance with an 8-cycle hold limit, one with no limit,
// both driven identically and compared against a behavioural arbitration model.
module tb_rr_arb4_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_arb4_ctrl_if bus8 ();
    rr_arb4_ctrl_if bus0 ();

    rr_arb4_ctrl #(.MAX_HOLD(8), .CNT_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    rr_arb4_ctrl #(.MAX_HOLD(0), .CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: granted client (-1 = none), cycles held, last winner.
    int m_cur[2]  = '{-1, -1};
    int m_cnt[2]  = '{0, 0};
    int m_last[2] = '{3, 3};
    int m_max[2]  = '{8, 0};

    function automatic int model_arb(logic [3:0] r, logic fp, int last);
        if (fp) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input int d, input logic [3:0] r, input logic fp, input logic rn);
        int w;
        int lim;
        logic [3:0] others;
        lim = (m_max[d] == 0) ? 15 : m_max[d];
        if (!rn) begin
            m_cur[d] = -1; m_cnt[d] = 0; m_last[d] = 3;
        end else if (m_cur[d] < 0) begin
            w = model_arb(r, fp, m_last[d]);
            if (w >= 0) begin m_cur[d] = w; m_cnt[d] = 1; m_last[d] = w; end
        end else begin
            others = r;
            others[m_cur[d]] = 1'b0;
            w = model_arb(others, fp, m_last[d]);
            if (!r[m_cur[d]]) begin
                if (w >= 0) begin m_cur[d] = w; m_cnt[d] = 1; m_last[d] = w; end
                else begin m_cur[d] = -1; m_cnt[d] = 0; end
            end else if (m_max[d] != 0 && m_cnt[d] == m_max[d]) begin
                if (w >= 0) begin m_cur[d] = w; m_last[d] = w; end
                m_cnt[d] = 1;
            end else if (m_cnt[d] < lim) begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end
    endtask

    // Expected {grant, grant_idx, grant_valid} for a granted client (-1 = none).
    function automatic logic [6:0] vec(int c);
        logic [3:0] g;
        if (c < 0) return 7'b0;
        g = 4'b0001 << c;
        return {g, 2'(c), 1'b1};
    endfunction

    task automatic tick(input logic [3:0] r, input logic fp, input logic rn);
        bus8.req = r; bus0.req = r;
        bus8.fixed_pri = fp; bus0.fixed_pri = fp;
        rst_n = rn;
        @(posedge clk);
        model_edge(0, r, fp, rn);
        model_edge(1, r, fp, rn);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] a;
        tick(4'b1111, 1'b0, 1'b0);
        tick(4'b1111, 1'b0, 1'b0);
        a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
        n_tests++;
        if (a !== 7'b0) begin n_fail++; $display("FAIL reset_hold8: got %b want %b", a, 7'b0); end
        a = {bus0.grant, bus0.grant_idx, bus0.grant_valid};
        n_tests++;
        if (a !== 7'b0) begin n_fail++; $display("FAIL reset_hold0: got %b want %b", a, 7'b0); end
        for (int i = 0; i < 2; i++) begin
            tick(4'b0000, 1'b0, 1'b1);
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== 7'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want %b", a, 7'b0); end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] rq[3] = '{4'b0110, 4'b0010, 4'b0000};
        int want[3] = '{2, 1, -1};
        logic [6:0] a;
        for (int i = 0; i < 3; i++) begin
            tick(rq[i], 1'b1, 1'b1);
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== vec(want[i])) begin
                n_fail++; $display("FAIL fixed_step%0d: got %b want %b", i, a, vec(want[i]));
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] r;
        logic [3:0] g;
        logic [6:0] a;
        int exp_c;
        tick(4'b1111, 1'b0, 1'b0);
        r = 4'b1111;
        exp_c = 0;
        for (int k = 0; k < 5; k++) begin
            tick(r, 1'b0, 1'b1);
            a = {bus0.grant, bus0.grant_idx, bus0.grant_valid};
            n_tests++;
            if (a !== vec(exp_c)) begin
                n_fail++; $display("FAIL rotation_hold0_%0d: got %b want %b", k, a, vec(exp_c));
            end
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== vec(exp_c)) begin
                n_fail++; $display("FAIL rotation_hold8_%0d: got %b want %b", k, a, vec(exp_c));
            end
            // Holder drops its request for one edge; everyone else keeps asking.
            g = 4'b0001 << exp_c;
            r = 4'b1111 & ~g;
            exp_c = (exp_c + 1) % 4;
        end
    endtask

    task automatic test_timeout();
        logic [6:0] a;
        tick(4'b0011, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick(4'b0011, 1'b0, 1'b1);
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== vec((i / 8) % 2)) begin
                n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", i, a, vec((i / 8) % 2));
            end
            a = {bus0.grant, bus0.grant_idx, bus0.grant_valid};
            n_tests++;
            if (a !== vec(0)) begin
                n_fail++; $display("FAIL unlimited_hold_cycle%0d: got %b want %b", i, a, vec(0));
            end
        end
    endtask

    task automatic test_single_timeout();
        logic [6:0] a;
        tick(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(4'b1000, 1'b0, 1'b1);
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== vec(3)) begin
                n_fail++; $display("FAIL single_regrant_cycle%0d: got %b want %b", i, a, vec(3));
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [6:0] a;
        tick(4'b0000, 1'b1, 1'b0);
        tick(4'b0100, 1'b1, 1'b1);
        a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
        n_tests++;
        if (a !== vec(2)) begin n_fail++; $display("FAIL midreset_setup: got %b want %b", a, vec(2)); end
        tick(4'b1111, 1'b0, 1'b0);
        a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
        n_tests++;
        if (a !== vec(-1)) begin n_fail++; $display("FAIL midreset_clear: got %b want %b", a, vec(-1)); end
        tick(4'b1111, 1'b0, 1'b1);
        a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
        n_tests++;
        if (a !== vec(0)) begin n_fail++; $display("FAIL midreset_restart: got %b want %b", a, vec(0)); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic fp;
        logic rn;
        logic [6:0] a;
        r = 4'($urandom_range(0, 15));
        fp = 1'b0;
        tick(r, fp, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r = r ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) fp = ~fp;
            rn = ($urandom_range(0, 39) != 0);
            tick(r, fp, rn);
            a = {bus8.grant, bus8.grant_idx, bus8.grant_valid};
            n_tests++;
            if (a !== vec(m_cur[0])) begin
                n_fail++; $display("FAIL random_hold8_cycle%0d: got %b want %b", i, a, vec(m_cur[0]));
            end
            a = {bus0.grant, bus0.grant_idx, bus0.grant_valid};
            n_tests++;
            if (a !== vec(m_cur[1])) begin
                n_fail++; $display("FAIL random_hold0_cycle%0d: got %b want %b", i, a, vec(m_cur[1]));
            end
        end
    endtask

    initial begin
        bus8.req = 4'b0000; bus0.req = 4'b0000;
        bus8.fixed_pri = 1'b0; bus0.fixed_pri = 1'b0;
        test_reset();
        test_fixed();
        test_rotation();
        test_timeout();
        test_single_timeout();
        test_reset_mid_grant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
